// File: rtl/lock_monitor_pkg.sv
// Shared constants for the MMCM lock monitor: state encodings, default parameters
// and the hold-counter width helper.
package lock_monitor_pkg;

    localparam int DEF_NUM_MMCMS   = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 1024;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Hold counter only ever reaches HOLD_CYCLES-1, so clog2 bits suffice (min 1).
    function automatic int hold_cnt_width(input int hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage

// File: rtl/lock_monitor_sync_ff.sv
// Single-bit multi-flop synchronizer for an asynchronous LOCKED pin.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/lock_monitor.sv
// Qualifies the LOCKED pins of several MMCMs into one lock signal and records unlock history.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_UNLOCKED | at least one synced LOCKED pin low; waiting for all high
// ST_QUALIFY  | all pins high; counting HOLD_CYCLES consecutive cycles
// ST_LOCKED   | qualified lock; any low pin is an unlock event
module lock_monitor
    import lock_monitor_pkg::*;
#(
    parameter int NUM_MMCMS   = DEF_NUM_MMCMS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NUM_MMCMS-1:0] mmcm_locked_i,
    input  logic                 clear_i,
    output logic                 mmcms_locked_o,
    output logic                 lost_lock_o,
    output logic [CNT_WIDTH-1:0] unlock_cnt_o,
    output logic [NUM_MMCMS-1:0] unlock_mask_o
);

    localparam int                 HOLD_W    = hold_cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    lock_state_t           state;
    lock_state_t           state_nxt;
    logic [NUM_MMCMS-1:0]  locked_sync;
    logic                  all_locked;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  unlock_event;

    for (genvar g = 0; g < NUM_MMCMS; g++) begin : g_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .d       (mmcm_locked_i[g]),
            .q       (locked_sync[g])
        );
    end

    assign all_locked = &locked_sync;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: if (all_locked) state_nxt = ST_QUALIFY;
            ST_QUALIFY: begin
                if (!all_locked) begin
                    state_nxt = ST_UNLOCKED;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED:   if (!all_locked) state_nxt = ST_UNLOCKED;
            default:     state_nxt = ST_UNLOCKED;
        endcase
    end

    always_comb begin
        mmcms_locked_o = (state == ST_LOCKED);
        unlock_event   = (state == ST_LOCKED) && !all_locked;
    end

    // Held at zero outside QUALIFY, so every qualification attempt starts from 0.
    always_ff @(posedge clock_i) begin
        if (reset_i || state != ST_QUALIFY) begin
            hold_cnt <= '0;
        end else if (all_locked && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // An unlock event on the same edge as clear wins: history restarts with that event.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            unlock_cnt_o  <= '0;
            lost_lock_o   <= 1'b0;
            unlock_mask_o <= '0;
        end else if (unlock_event) begin
            lost_lock_o <= 1'b1;
            if (clear_i) begin
                unlock_cnt_o  <= CNT_WIDTH'(1);
                unlock_mask_o <= ~locked_sync;
            end else begin
                if (unlock_cnt_o != CNT_MAX) begin
                    unlock_cnt_o <= unlock_cnt_o + CNT_WIDTH'(1);
                end
                unlock_mask_o <= unlock_mask_o | ~locked_sync;
            end
        end else if (clear_i) begin
            unlock_cnt_o  <= '0;
            lost_lock_o   <= 1'b0;
            unlock_mask_o <= '0;
        end
    end

endmodule

// File: tb/tb_lock_monitor.sv
// Self-checking bench for lock_monitor: directed vector table, corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_lock_monitor;

    localparam int NM = 3;
    localparam int SS = 2;
    localparam int HC = 8;
    localparam int CW = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          clear_i = 1'b0;
    logic [NM-1:0] mmcm_locked_i = '0;
    logic          mmcms_locked_o;
    logic          lost_lock_o;
    logic [CW-1:0] unlock_cnt_o;
    logic [NM-1:0] unlock_mask_o;

    int checks   = 0;
    int failures = 0;

    always #5 clock_i = ~clock_i;

    lock_monitor #(
        .NUM_MMCMS   (NM),
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HC),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .mmcm_locked_i  (mmcm_locked_i),
        .clear_i        (clear_i),
        .mmcms_locked_o (mmcms_locked_o),
        .lost_lock_o    (lost_lock_o),
        .unlock_cnt_o   (unlock_cnt_o),
        .unlock_mask_o  (unlock_mask_o)
    );

    // Reference: the FSM sees each input SS edges late; lock is declared once it has
    // seen all-high on HC+1 consecutive edges, and dropped on the first edge seeing a low.
    logic [NM-1:0] hist [SS];
    logic [NM-1:0] m_synced;
    logic          m_all;
    logic          m_locked = 1'b0;
    logic          m_lost   = 1'b0;
    int            m_cnt    = 0;
    logic [NM-1:0] m_mask   = '0;
    int            m_run    = 0;

    always @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < SS; i++) hist[i] = '0;
            m_run = 0; m_locked = 1'b0; m_lost = 1'b0; m_cnt = 0; m_mask = '0;
        end else begin
            m_synced = hist[SS-1];
            m_all    = &m_synced;
            m_run    = m_all ? m_run + 1 : 0;
            if (m_locked && !m_all) begin
                m_locked = 1'b0;
                m_lost   = 1'b1;
                m_cnt    = clear_i ? 1 : ((m_cnt < (2**CW) - 1) ? m_cnt + 1 : m_cnt);
                m_mask   = (clear_i ? '0 : m_mask) | ~m_synced;
            end else begin
                if (clear_i) begin
                    m_cnt = 0; m_lost = 1'b0; m_mask = '0;
                end
                if (!m_locked && m_run >= HC + 1) m_locked = 1'b1;
            end
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = mmcm_locked_i;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_all(input string tag, input int lk, input int lost, input int cnt, input int mask);
        check({tag, ".locked"}, int'(mmcms_locked_o), lk);
        check({tag, ".lost"},   int'(lost_lock_o),    lost);
        check({tag, ".cnt"},    int'(unlock_cnt_o),   cnt);
        check({tag, ".mask"},   int'(unlock_mask_o),  mask);
    endtask

    typedef struct {
        logic          rst;
        logic          clr;
        logic [NM-1:0] pins;
        int            n;
        logic          e_lk;
        logic          e_lost;
        int            e_cnt;
        logic [NM-1:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Edge 1 is the first edge sampling the new input value.
        vecs.push_back('{1'b1, 1'b0, 3'b111,  2, 1'b0, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111, 10, 1'b0, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b101,  1, 1'b1, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b0, 1'b1, 1, 3'b010});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  8, 1'b0, 1'b1, 1, 3'b010});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b1, 1, 3'b010});
        vecs.push_back('{1'b0, 1'b1, 3'b111,  1, 1'b1, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b110,  3, 1'b0, 1'b1, 1, 3'b001});
        vecs.push_back('{1'b0, 1'b0, 3'b111, 10, 1'b0, 1'b1, 1, 3'b001});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b1, 1, 3'b001});
        vecs.push_back('{1'b1, 1'b0, 3'b111,  1, 1'b0, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111, 10, 1'b0, 1'b0, 0, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 3'b111,  1, 1'b1, 1'b0, 0, 3'b000});

        step();
        step();

        foreach (vecs[k]) begin
            reset_i       = vecs[k].rst;
            clear_i       = vecs[k].clr;
            mmcm_locked_i = vecs[k].pins;
            for (int c = 0; c < vecs[k].n; c++) begin
                step();
                clear_i = 1'b0;
            end
            check_all($sformatf("vec%0d", k), int'(vecs[k].e_lk), int'(vecs[k].e_lost),
                      vecs[k].e_cnt, int'(vecs[k].e_mask));
        end

        // Glitch after 5 qualify cycles: no lock, and a full requalification from recovery.
        reset_i = 1'b1; step(); reset_i = 1'b0;
        mmcm_locked_i = 3'b111;
        for (int c = 0; c < 8; c++) begin
            step();
            check("glitch.pre", int'(mmcms_locked_o), 0);
        end
        mmcm_locked_i = 3'b110;
        step(); step();
        mmcm_locked_i = 3'b111;
        for (int c = 1; c <= 10; c++) begin
            step();
            check("glitch.requal", int'(mmcms_locked_o), 0);
        end
        step();
        check_all("glitch.lock", 1, 0, 0, 0);

        // Clear on the same edge as an unlock event, then clear on its own.
        mmcm_locked_i = 3'b101; step();
        mmcm_locked_i = 3'b111;
        repeat (13) step();
        check_all("preclr", 1, 1, 1, 3'b010);
        mmcm_locked_i = 3'b011; step();
        mmcm_locked_i = 3'b111; step();
        clear_i = 1'b1; step(); clear_i = 1'b0;
        check_all("clr_evt", 0, 1, 1, 3'b100);
        repeat (12) step();
        check("clr_evt.relock", int'(mmcms_locked_o), 1);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        check_all("clr_only", 1, 0, 0, 0);

        // Saturation over 17 unlock events.
        reset_i = 1'b1; step(); reset_i = 1'b0;
        mmcm_locked_i = 3'b111;
        repeat (12) step();
        check("sat.locked", int'(mmcms_locked_o), 1);
        for (int k = 1; k <= 17; k++) begin
            mmcm_locked_i = 3'($urandom_range(0, 6));
            step();
            mmcm_locked_i = 3'b111;
            repeat (13) step();
            check($sformatf("sat.cnt%0d", k), int'(unlock_cnt_o), (k < 15) ? k : 15);
            check($sformatf("sat.lk%0d", k), int'(mmcms_locked_o), 1);
        end

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset_i       = ($urandom_range(0, 499) == 0);
            clear_i       = ($urandom_range(0, 39) == 0);
            mmcm_locked_i = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            step();
            check("rnd.locked", int'(mmcms_locked_o), int'(m_locked));
            check("rnd.lost",   int'(lost_lock_o),    int'(m_lost));
            check("rnd.cnt",    int'(unlock_cnt_o),   m_cnt);
            check("rnd.mask",   int'(unlock_mask_o),  int'(m_mask));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_monitor.md
LOCK_MONITOR -- requirements
Module: lock_monitor

Interface
REQ-001 Parameter NUM_MMCMS, 3, number of MMCM lock inputs monitored.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer depth per lock input (min 2).
REQ-003 Parameter HOLD_CYCLES, 1024, consecutive all-locked cycles required before declaring lock (min 1).
REQ-004 Parameter CNT_WIDTH, 16, width of unlock-event counter.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock_i  input  1  free-running system clock; all logic on rising edge.
REQ-007 reset_i  input  1  synchronous active-high reset.
REQ-008 mmcm_locked_i  input  NUM_MMCMS  raw asynchronous LOCKED pins of each MMCM.
REQ-009 clear_i  input  1  single-cycle pulse; clears counter, sticky flag, mask.
REQ-010 mmcms_locked_o  output  1  qualified lock; drives the startup reset generator's lock input.
REQ-011 lost_lock_o  output  1  sticky: lock lost at least once since reset/clear.
REQ-012 unlock_cnt_o  output  CNT_WIDTH  saturating count of LOCKED->UNLOCKED transitions.
REQ-013 unlock_mask_o  output  NUM_MMCMS  sticky OR of synced inputs found low at each unlock event.

Function
REQ-014 Each mmcm_locked_i bit SHALL pass through its own SYNC_STAGES-flop synchronizer; only synced values feed the FSM.
REQ-015 all_locked SHALL be the AND of all synced bits.
REQ-016 FSM states: UNLOCKED, QUALIFY, LOCKED; mmcms_locked_o = (state == LOCKED), decoded from the state register, no extra delay.
REQ-017 UNLOCKED: all_locked -> QUALIFY with hold counter cleared to 0; else stay.
REQ-018 QUALIFY: !all_locked -> UNLOCKED, no counter/flag update; all_locked and hold counter == HOLD_CYCLES-1 -> LOCKED; otherwise hold counter +1.
REQ-019 LOCKED: !all_locked -> UNLOCKED on the same edge: unlock_cnt_o +1 (saturating), lost_lock_o set, unlock_mask_o |= ~synced bits.
REQ-020 Latency: inputs all high and steady -> mmcms_locked_o rises exactly SYNC_STAGES+HOLD_CYCLES+1 edges after the first edge sampling them all high.
REQ-021 Any input low while LOCKED -> mmcms_locked_o falls exactly SYNC_STAGES+1 edges after the first edge sampling it low.
REQ-022 Glitch shorter than HOLD_CYCLES during QUALIFY SHALL restart qualification from 0 on the next all_locked.
REQ-023 unlock_cnt_o SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-024 clear_i SHALL zero unlock_cnt_o, lost_lock_o, unlock_mask_o next edge; FSM and mmcms_locked_o unaffected.
REQ-025 clear_i coincident with unlock event: event wins over clear -> counter = 1, lost_lock_o = 1, mask = bits low at that event only.
REQ-026 Hold counter width SHALL be $clog2(HOLD_CYCLES) minimum 1 bit; no overflow possible.

Reset
REQ-027 reset_i SHALL, on the next edge: state = UNLOCKED, hold counter 0, all synchronizer flops 0, mmcms_locked_o 0, lost_lock_o 0, unlock_cnt_o 0, unlock_mask_o 0.
REQ-028 Reset mid-QUALIFY or mid-LOCKED SHALL not count as an unlock event; after release, full REQ-020 latency applies again.
REQ-029 Power-up initial values SHALL equal reset values.

Structure
REQ-030 FSM state encodings and the default parameter values SHALL live in the shared control-block constants header.
REQ-031 One sub-module: sync_ff (parameterized depth, single bit), instantiated NUM_MMCMS times.
REQ-032 Estimated size 150-250 lines RTL total.

Verification (SYNC_STAGES=2, HOLD_CYCLES=8, NUM_MMCMS=3, CNT_WIDTH=4)
REQ-033 Release reset, hold inputs 3'b111 -> mmcms_locked_o rises exactly 11 edges after first sampled high; counter 0, lost_lock_o 0.
REQ-034 Locked, drop bit1 for 1 cycle -> mmcms_locked_o falls 3 edges later; unlock_cnt_o = 1, lost_lock_o = 1, unlock_mask_o = 3'b010; relock after 11 more edges.
REQ-035 Inputs high then bit0 low for 2 cycles after 5 qualify cycles -> no lock, counter unchanged; relock takes full 8 hold cycles from recovery.
REQ-036 Force 17 unlock events -> unlock_cnt_o sticks at 15.
REQ-037 clear_i on the same edge as an unlock event -> unlock_cnt_o = 1, lost_lock_o = 1; clear_i alone later -> all three zero, mmcms_locked_o unchanged.
REQ-038 reset_i while LOCKED -> all outputs 0 next edge, counter not incremented; relock after 11 edges.
